// File: rtl/rc4_pkg.sv
// Shared widths, state encoding and helpers for the RC4 controller slice.
package rc4_pkg;

    localparam int unsigned DATA_WIDTH = 8;
    localparam int unsigned ADDR_WIDTH = 8;
    localparam int unsigned KEY_WIDTH  = 24;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        KSA   = 3'd2,
        DEC   = 3'd3,
        DONE  = 3'd4,
        ERROR = 3'd5
    } rc4_state_t;

    // True for the three states that own the S port and run the watchdog.
    function automatic logic is_run_state(input rc4_state_t s);
        return (s == INIT) || (s == KSA) || (s == DEC);
    endfunction

endpackage

// File: rtl/rc4_s_mem_mux.sv
// Grants the single S RAM port to the phase owning the current state.
module rc4_s_mem_mux
    import rc4_pkg::*;
(
    input  rc4_state_t              state,
    input  logic [ADDR_WIDTH-1:0]   init_s_addr,
    input  logic [DATA_WIDTH-1:0]   init_s_data,
    input  logic                    init_s_wren,
    input  logic [ADDR_WIDTH-1:0]   ksa_s_addr,
    input  logic [DATA_WIDTH-1:0]   ksa_s_data,
    input  logic                    ksa_s_wren,
    input  logic [ADDR_WIDTH-1:0]   dec_s_addr,
    input  logic [DATA_WIDTH-1:0]   dec_s_data,
    input  logic                    dec_s_wren,
    output logic [ADDR_WIDTH-1:0]   s_addr,
    output logic [DATA_WIDTH-1:0]   s_data,
    output logic                    s_wren
);

    // Route the owning phase; non-run states drive a write-safe zero.
    always_comb begin
        s_addr = '0;
        s_data = '0;
        s_wren = 1'b0;
        case (state)
            INIT: begin
                s_addr = init_s_addr;
                s_data = init_s_data;
                s_wren = init_s_wren;
            end
            KSA: begin
                s_addr = ksa_s_addr;
                s_data = ksa_s_data;
                s_wren = ksa_s_wren;
            end
            DEC: begin
                s_addr = dec_s_addr;
                s_data = dec_s_data;
                s_wren = dec_s_wren;
            end
            default: begin
                s_addr = '0;
                s_data = '0;
                s_wren = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/rc4_controller.sv
// Sequences init -> KSA -> decrypt, owns the S port grant, latches the key
// and bounds every phase with a watchdog.
module rc4_controller
    import rc4_pkg::*;
#(
    parameter int unsigned PHASE_TIMEOUT = 4096
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [KEY_WIDTH-1:0]    key,
    output logic                    finish,
    output logic                    error,
    output logic [KEY_WIDTH-1:0]    key_q,
    output logic                    init_start,
    output logic                    ksa_start,
    output logic                    dec_start,
    input  logic                    init_finish,
    input  logic                    ksa_finish,
    input  logic                    dec_finish,
    input  logic [ADDR_WIDTH-1:0]   init_s_addr,
    input  logic [ADDR_WIDTH-1:0]   ksa_s_addr,
    input  logic [ADDR_WIDTH-1:0]   dec_s_addr,
    input  logic [DATA_WIDTH-1:0]   init_s_data,
    input  logic [DATA_WIDTH-1:0]   ksa_s_data,
    input  logic [DATA_WIDTH-1:0]   dec_s_data,
    input  logic                    init_s_wren,
    input  logic                    ksa_s_wren,
    input  logic                    dec_s_wren,
    output logic [ADDR_WIDTH-1:0]   s_addr,
    output logic [DATA_WIDTH-1:0]   s_data,
    output logic                    s_wren
);

    localparam int unsigned WD_W = (PHASE_TIMEOUT > 2) ? $clog2(PHASE_TIMEOUT) : 1;

    rc4_state_t         state;
    rc4_state_t         state_next;
    logic [WD_W-1:0]    wd;
    logic               wd_expired;

    // Next-state decode; a phase finish beats a same-cycle watchdog expiry.
    always_comb begin
        state_next = state;
        wd_expired = (wd == WD_W'(PHASE_TIMEOUT - 1));
        case (state)
            IDLE:  if (start)            state_next = INIT;
            INIT:  if (init_finish)      state_next = KSA;
                   else if (wd_expired)  state_next = ERROR;
            KSA:   if (ksa_finish)       state_next = DEC;
                   else if (wd_expired)  state_next = ERROR;
            DEC:   if (dec_finish)       state_next = DONE;
                   else if (wd_expired)  state_next = ERROR;
            DONE:  if (!start)           state_next = IDLE;
            ERROR:                       state_next = ERROR;
            default:                     state_next = IDLE;
        endcase
    end

    // State, watchdog, key latch and registered phase/status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wd         <= '0;
            key_q      <= '0;
            init_start <= 1'b0;
            ksa_start  <= 1'b0;
            dec_start  <= 1'b0;
            finish     <= 1'b0;
            error      <= 1'b0;
        end else begin
            state <= state_next;
            if (state_next != state)
                wd <= '0;
            else if (is_run_state(state))
                wd <= wd + WD_W'(1);
            else
                wd <= '0;
            if (state == IDLE && start)
                key_q <= key;
            init_start <= (state_next == INIT);
            ksa_start  <= (state_next == KSA);
            dec_start  <= (state_next == DEC);
            finish     <= (state_next == DONE);
            error      <= (state_next == ERROR);
        end
    end

    rc4_s_mem_mux u_s_mem_mux (
        .state       (state),
        .init_s_addr (init_s_addr),
        .init_s_data (init_s_data),
        .init_s_wren (init_s_wren),
        .ksa_s_addr  (ksa_s_addr),
        .ksa_s_data  (ksa_s_data),
        .ksa_s_wren  (ksa_s_wren),
        .dec_s_addr  (dec_s_addr),
        .dec_s_data  (dec_s_data),
        .dec_s_wren  (dec_s_wren),
        .s_addr      (s_addr),
        .s_data      (s_data),
        .s_wren      (s_wren)
    );

endmodule

// File: tb/tb_rc4_controller.sv
// Directed bench for rc4_controller with stubbed phase blocks and a phase-length scoreboard.
module tb_rc4_controller;
    import rc4_pkg::*;

    localparam int unsigned TO     = 1024;
    localparam int unsigned L_INIT = 256;
    localparam int unsigned L_KSA  = 768;
    localparam int unsigned L_DEC  = 64;
    localparam int unsigned RUN_EDGES = 1 + L_INIT + L_KSA + L_DEC;

    logic                  clk, rst, start;
    logic [KEY_WIDTH-1:0]  key, key_q;
    logic                  finish, error;
    logic                  init_start, ksa_start, dec_start;
    logic                  init_finish, ksa_finish, dec_finish;
    logic [ADDR_WIDTH-1:0] init_s_addr, ksa_s_addr, dec_s_addr, s_addr;
    logic [DATA_WIDTH-1:0] init_s_data, ksa_s_data, dec_s_data, s_data;
    logic                  init_s_wren, ksa_s_wren, dec_s_wren, s_wren;

    logic        ksa_hang, dec_force, mon_en;
    logic [15:0] init_cnt, ksa_cnt, dec_cnt;
    int          cyc, vectors, errors;

    typedef struct { int phase; int len; } exp_t;
    exp_t exp_q[$];

    rc4_controller #(.PHASE_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .key(key),
        .finish(finish), .error(error), .key_q(key_q),
        .init_start(init_start), .ksa_start(ksa_start), .dec_start(dec_start),
        .init_finish(init_finish), .ksa_finish(ksa_finish), .dec_finish(dec_finish),
        .init_s_addr(init_s_addr), .ksa_s_addr(ksa_s_addr), .dec_s_addr(dec_s_addr),
        .init_s_data(init_s_data), .ksa_s_data(ksa_s_data), .dec_s_data(dec_s_data),
        .init_s_wren(init_s_wren), .ksa_s_wren(ksa_s_wren), .dec_s_wren(dec_s_wren),
        .s_addr(s_addr), .s_data(s_data), .s_wren(s_wren)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Phase stubs: each counts cycles of its start and finishes after its fixed latency.
    always @(posedge clk) begin
        init_cnt <= init_start ? init_cnt + 16'd1 : 16'd0;
        ksa_cnt  <= ksa_start  ? ksa_cnt  + 16'd1 : 16'd0;
        dec_cnt  <= dec_start  ? dec_cnt  + 16'd1 : 16'd0;
    end
    assign init_finish = init_start && (init_cnt == 16'(L_INIT - 1));
    assign ksa_finish  = ksa_start && !ksa_hang && (ksa_cnt == 16'(L_KSA - 1));
    assign dec_finish  = (dec_start && (dec_cnt == 16'(L_DEC - 1))) || dec_force;
    assign init_s_addr = init_cnt[7:0];
    assign init_s_data = ~init_cnt[7:0];
    assign init_s_wren = 1'b1;
    assign ksa_s_addr  = 8'h5A ^ ksa_cnt[7:0];
    assign ksa_s_data  = ksa_cnt[7:0] + 8'd3;
    assign ksa_s_wren  = ksa_cnt[0];
    assign dec_s_addr  = 8'hC0 | dec_cnt[7:0];
    assign dec_s_data  = 8'h33;
    assign dec_s_wren  = ~dec_cnt[0];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Per-cycle monitor: one-hot starts, S-port routing, and phase lengths vs scoreboard.
    logic [2:0] prev_st;
    int         run_len [3];
    logic [7:0] ea, ed;
    logic       ew;
    always @(negedge clk) begin
        if (mon_en) begin
            logic [2:0] st;
            st = {dec_start, ksa_start, init_start};
            check("start_onehot", 32'($countones(st) <= 1), 32'd1);
            ea = 8'd0; ed = 8'd0; ew = 1'b0;
            if (init_start)     begin ea = init_s_addr; ed = init_s_data; ew = init_s_wren; end
            else if (ksa_start) begin ea = ksa_s_addr;  ed = ksa_s_data;  ew = ksa_s_wren;  end
            else if (dec_start) begin ea = dec_s_addr;  ed = dec_s_data;  ew = dec_s_wren;  end
            check("s_port", {15'd0, s_wren, s_data, s_addr}, {15'd0, ew, ed, ea});
            for (int p = 0; p < 3; p++) begin
                if (st[p]) run_len[p]++;
                else if (prev_st[p]) begin
                    if (exp_q.size() == 0) check("phase_unexpected", 32'(p), 32'd99);
                    else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check("phase_id", 32'(p), 32'(e.phase));
                        check("phase_len", 32'(run_len[p]), 32'(e.len));
                    end
                    run_len[p] = 0;
                end
            end
            prev_st = st;
        end
    end

    task automatic push_exp(input int phase, input int len);
        exp_t e;
        e.phase = phase;
        e.len   = len;
        exp_q.push_back(e);
    endtask

    // Wait (bounded) for finish or error; returns edges elapsed since t0.
    task automatic wait_status(input int t0, input int limit, output int dt);
        int n;
        n = 0;
        while (!finish && !error && n < limit) begin
            @(negedge clk);
            n++;
        end
        dt = cyc - t0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check(tag, {26'd0, init_start, ksa_start, dec_start, finish, error, s_wren},
              32'd0);
    endtask

    initial begin
        int t0, dt;
        vectors = 0; errors = 0; mon_en = 1'b0;
        prev_st = 3'b000;
        for (int p = 0; p < 3; p++) run_len[p] = 0;
        rst = 1'b1; start = 1'b0; key = '0; ksa_hang = 1'b0; dec_force = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        check_idle_outputs("reset_outputs");
        check("reset_key_q", 32'(key_q), 32'd0);
        check("reset_s_addr", {16'd0, s_addr, s_data}, 32'd0);
        rst = 1'b0;
        mon_en = 1'b1;
        repeat (3) @(negedge clk);
        check_idle_outputs("idle_outputs");

        // Run 1: full run with start held, stays in DONE
        key = 24'h000249; start = 1'b1; t0 = cyc;
        push_exp(0, L_INIT); push_exp(1, L_KSA); push_exp(2, L_DEC);
        @(negedge clk);
        check("init_start_rise", {31'd0, init_start}, 32'd1);
        wait_status(t0, 3000, dt);
        check("run1_finish_latency", 32'(dt), 32'(RUN_EDGES));
        check("run1_key_q", 32'(key_q), 32'h000249);
        repeat (10) @(negedge clk);
        check("done_hold", {30'd0, finish, error}, 32'd2);
        start = 1'b0;
        @(negedge clk);
        check("done_exit", {31'd0, finish}, 32'd0);
        @(negedge clk);

        // Run 2: stray dec_finish in INIT, start toggle and key change in KSA
        start = 1'b1; t0 = cyc;
        push_exp(0, L_INIT); push_exp(1, L_KSA); push_exp(2, L_DEC);
        repeat (100) @(negedge clk);
        dec_force = 1'b1;
        @(negedge clk);
        dec_force = 1'b0;
        repeat (300) @(negedge clk);
        check("run2_in_ksa", {31'd0, ksa_start}, 32'd1);
        start = 1'b0; key = 24'hFFFFFF;
        repeat (2) @(negedge clk);
        start = 1'b1;
        wait_status(t0, 3000, dt);
        check("run2_finish_latency", 32'(dt), 32'(RUN_EDGES));
        check("run2_key_q", 32'(key_q), 32'h000249);
        start = 1'b0;
        repeat (2) @(negedge clk);

        // Run 3: reset during KSA, then a clean rerun with a new key
        key = 24'h00ABCD; start = 1'b1; t0 = cyc;
        push_exp(0, L_INIT); push_exp(1, 300 - 1 - L_INIT + 1);
        repeat (300) @(negedge clk);
        check("run3_in_ksa", {31'd0, ksa_start}, 32'd1);
        rst = 1'b1; start = 1'b0;
        @(negedge clk);
        check_idle_outputs("midrun_reset_outputs");
        check("midrun_reset_key_q", 32'(key_q), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        start = 1'b1; t0 = cyc;
        push_exp(0, L_INIT); push_exp(1, L_KSA); push_exp(2, L_DEC);
        wait_status(t0, 3000, dt);
        check("rerun_finish_latency", 32'(dt), 32'(RUN_EDGES));
        check("rerun_key_q", 32'(key_q), 32'h00ABCD);
        start = 1'b0;
        repeat (2) @(negedge clk);

        // Run 4: KSA never finishes -> watchdog error, sticky until reset
        ksa_hang = 1'b1; start = 1'b1; t0 = cyc;
        push_exp(0, L_INIT); push_exp(1, TO);
        wait_status(t0, 4000, dt);
        check("timeout_latency", 32'(dt), 32'(1 + L_INIT + TO));
        check("timeout_status", {30'd0, finish, error}, 32'd1);
        check("timeout_s_wren", {31'd0, s_wren}, 32'd0);
        start = 1'b0;
        repeat (5) @(negedge clk);
        start = 1'b1;
        repeat (20) @(negedge clk);
        check("error_sticky", {27'd0, init_start, ksa_start, dec_start, finish, error}, 32'd1);
        rst = 1'b1; start = 1'b0; ksa_hang = 1'b0;
        @(negedge clk);
        check_idle_outputs("error_reset");
        rst = 1'b0;
        repeat (3) @(negedge clk);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
